// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: instruction-memory request/response, decode-side
// valid/ready queue head, and branch redirect.
interface fetch_queue_if #(
  parameter int ADDR_WIDTH = 64
);
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_resp_valid;
  logic [31:0]           imem_resp_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_instruction;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_instruction, out_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, out_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_instruction, out_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, out_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Sequential instruction fetch with a single outstanding memory request, a
// first-word-fall-through instruction queue, and branch-redirect flush.
module fetch_queue_chk (
  input logic clock,
  input logic reset,
  input logic in_fetch,
  input logic resp_valid
);
  // A response may only arrive while a request is outstanding
  property p_no_resp_in_fetch;
    @(posedge clock) disable iff (reset) !(in_fetch && resp_valid);
  endproperty
  a_no_resp_in_fetch: assert property (p_no_resp_in_fetch);
endmodule

module fetch_queue #(
  parameter int                    DEPTH      = 4,
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input logic          clock,
  input logic          reset,
  fetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [ADDR_WIDTH-1:0] fetch_pc_r;
  logic [ADDR_WIDTH-1:0] pending_pc_r;
  logic [ADDR_WIDTH-1:0] redirect_target_s;
  logic [CNT_W-1:0]      count_r;
  logic [PTR_W-1:0]      head_r;
  logic [PTR_W-1:0]      tail_r;
  logic [31:0]           instr_mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_r    [DEPTH];
  logic                  out_valid_s;
  logic                  handshake_s;
  logic                  push_s;
  logic                  pop_s;

  assign redirect_target_s = bus.redirect_pc & ~ADDR_WIDTH'(3);

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_r <= ST_FETCH;
    else       state_r <= state_s;
  end

  // Next-state logic; any response leaving WAIT/DROP returns to FETCH
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (handshake_s) state_s = ST_WAIT;
        else             state_s = ST_FETCH;
      end
      ST_WAIT: begin
        if (bus.imem_resp_valid)     state_s = ST_FETCH;
        else if (bus.redirect_valid) state_s = ST_DROP;
        else                         state_s = ST_WAIT;
      end
      ST_DROP: begin
        if (bus.imem_resp_valid) state_s = ST_FETCH;
        else                     state_s = ST_DROP;
      end
      default: state_s = ST_FETCH;
    endcase
  end

  // Output and handshake decode
  always_comb begin
    out_valid_s        = (count_r != CNT_W'(0));
    bus.imem_req_valid = (state_r == ST_FETCH) && (count_r < CNT_W'(DEPTH))
                         && !bus.redirect_valid && !reset;
    bus.imem_req_addr  = fetch_pc_r;
    bus.out_valid      = out_valid_s;
    if (out_valid_s) begin
      bus.out_instruction = instr_mem_r[head_r];
      bus.out_pc          = pc_mem_r[head_r];
    end else begin
      bus.out_instruction = 32'h0;
      bus.out_pc          = '0;
    end
    handshake_s = bus.imem_req_valid && bus.imem_req_ready;
    push_s      = (state_r == ST_WAIT) && bus.imem_resp_valid && !bus.redirect_valid;
    pop_s       = out_valid_s && bus.out_ready && !bus.redirect_valid;
  end

  // Fetch PC; a redirect wins in every state
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_r   <= RESET_PC;
      pending_pc_r <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc_r <= redirect_target_s;
    end else if (handshake_s) begin
      pending_pc_r <= fetch_pc_r;
      fetch_pc_r   <= fetch_pc_r + ADDR_WIDTH'(4);
    end
  end

  // Queue pointers and occupancy; redirect flushes everything
  always_ff @(posedge clock) begin
    if (reset || bus.redirect_valid) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_s) tail_r <= tail_r + PTR_W'(1);
      if (pop_s)  head_r <= head_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue storage; contents are masked by count, so no reset is needed
  always_ff @(posedge clock) begin
    if (push_s) begin
      instr_mem_r[tail_r] <= bus.imem_resp_data;
      pc_mem_r[tail_r]    <= pending_pc_r;
    end
  end

  fetch_queue_chk u_chk (
    .clock      (clock),
    .reset      (reset),
    .in_fetch   (state_r == ST_FETCH),
    .resp_valid (bus.imem_resp_valid)
  );
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch front end that sits directly upstream of the CPU datapath's decode, control and register-read logic.
- Generates sequential fetch addresses from a local PC and issues them to instruction memory over a request/response handshake.
- Buffers returned 32-bit instructions, tagged with their PC, in a small FIFO, and presents them to decode with valid/ready.
- Accepts a branch redirect that flushes the queue and restarts fetch at the branch target.

Parameters:
DEPTH, 4, queue entries (power of two, >=2)
ADDR_WIDTH, 64, PC and address width
RESET_PC, 0, first fetch address after reset

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  instruction memory accepts request
imem_req_addr  out  ADDR_WIDTH  fetch address
imem_resp_valid  in  1  response data valid (one per accepted request)
imem_resp_data  in  32  fetched instruction
out_valid  out  1  queue head valid to decode
out_ready  in  1  decode consumes head
out_instruction  out  32  head instruction
out_pc  out  ADDR_WIDTH  head PC
redirect_valid  in  1  branch taken / flush
redirect_pc  in  ADDR_WIDTH  branch target

Behaviour:
- Single clock. Reset is synchronous and active-high, ports named clock and reset. No asynchronous behaviour.
- Reset sets state=FETCH, fetch_pc=RESET_PC, count=0 and pointers=0.
- During and immediately after reset: imem_req_valid=0 while reset is high, out_valid=0, out_instruction=0, out_pc=0.
- At most one memory request is outstanding. Response latency is >=1 cycle after acceptance, unbounded.
- imem_req_valid = (state==FETCH) && (count<DEPTH) && !redirect_valid && !reset. imem_req_addr = fetch_pc.
- Request handshake: imem_req_valid && imem_req_ready at a clock edge.
- State machine transitions:
  - FETCH, handshake: pending_pc<=fetch_pc; fetch_pc<=fetch_pc+4 (mod 2^ADDR_WIDTH, wraps to 0); go to WAIT.
  - FETCH, redirect_valid: fetch_pc<=redirect_pc; stay in FETCH. No request is issued in that cycle.
  - WAIT, imem_resp_valid && !redirect_valid: push {pending_pc, imem_resp_data}; go to FETCH.
  - WAIT, redirect_valid && imem_resp_valid: discard the response; fetch_pc<=redirect_pc; go to FETCH.
  - WAIT, redirect_valid && !imem_resp_valid: fetch_pc<=redirect_pc; go to DROP.
  - DROP, imem_resp_valid: discard the response; go to FETCH. A redirect in DROP updates fetch_pc and stays in DROP; a redirect coinciding with the response updates fetch_pc and still goes to FETCH.
- redirect_pc bits [1:0] are forced to 0 when loaded.
- Queue is first-word fall-through. out_valid = (count!=0). out_instruction/out_pc come from the head entry, and are 0 when empty.
- Pop: out_valid && out_ready. Push and pop in the same cycle leave count unchanged.
- A push occurring at edge N gives out_valid=1 in cycle N+1.
- Full: count==DEPTH blocks new requests. The outstanding request always has a reserved slot because it is issued only when count<DEPTH, so an overflow is impossible.
- Redirect: count<=0 and pointers<=0 at the edge. Any same-cycle pop or push is ignored. out_valid=0 the next cycle. The first request to the target is issued the cycle after the redirect (or after the DROP response).
- imem_resp_valid while in FETCH is a protocol violation: ignored, with a simulation assertion.
- Reset mid-operation (WAIT or DROP, queue non-empty): returns to the reset state. A late response arriving after reset lands in FETCH and is ignored. Memory must also be reset.

Test Plan:
- Reset, then memory with 2-cycle latency and out_ready=1 -> requests at 0x0, 0x4, 0x8; decode sees (pc 0x0, instr word 0), then 0x4, 0x8 in order; out_valid first rises 1 cycle after the first response.
- out_ready=0, DEPTH=4 -> exactly 4 entries fill (PCs 0x0 to 0xC), imem_req_valid stays 0 with count=4; raise out_ready -> one pop per cycle, fetch resumes at 0x10.
- Redirect to 0x1003 while in WAIT with no response -> DROP, the late response is discarded, queue empty, next request address 0x1000, first delivered out_pc=0x1000.
- Redirect in the same cycle as imem_resp_valid and a pop with count=2 -> response discarded, count=0, out_valid=0 next cycle, next request at redirect_pc.
- RESET_PC = 2^64-4 -> second request address wraps to 0x0.
- Assert reset while in WAIT with count=3 -> next cycle out_valid=0, count=0, first request at RESET_PC; the stale response is ignored.
